fetch_decode_reg: RTL and testbench

FETCH_DECODE_REG -- requirements
Module: fetch_decode_reg

---
 rtl/fetch_decode_reg_pkg.sv | 61 ++++++
 rtl/fetch_decode_reg_addr_check.sv | 17 +
 rtl/fetch_decode_reg.sv | 104 ++++++++++
 tb/tb_fetch_decode_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_reg_pkg.sv
// Shared pipeline definitions for the fetch-to-decode register: exception
// codes, the D-stage register bundle and the per-cycle action decode.
package fetch_decode_reg_pkg;

  // Exception codes shared by the pipeline stages.
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Instruction word loaded into D for bubbles and faulting fetches.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Distance from an instruction to its link address (skips the delay slot).
  localparam logic [31:0] LINK_OFFSET = 32'd8;

  // What the stage does in a given cycle, highest priority first.
  typedef enum logic [1:0] {
    ActReset   = 2'd0,
    ActFlush   = 2'd1,
    ActStall   = 2'd2,
    ActAdvance = 2'd3
  } stage_act_e;

  // Everything held in the D stage except the issue counter.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        bd;
    logic [4:0]  exc;
    logic        valid;
  } d_regs_t;

  // Resolve the control inputs into a single action.
  function automatic stage_act_e decode_act(input logic reset, input logic flush,
                                            input logic en);
    stage_act_e act;
    if (reset) begin
      act = ActReset;
    end else if (flush) begin
      act = ActFlush;
    end else if (!en) begin
      act = ActStall;
    end else begin
      act = ActAdvance;
    end
    return act;
  endfunction

  // D-stage contents after reset for a given reset PC.
  function automatic d_regs_t reset_regs(input logic [31:0] reset_pc);
    d_regs_t r;
    r.instr = NOP_INSTR;
    r.pc    = reset_pc;
    r.pc8   = reset_pc + LINK_OFFSET;
    r.bd    = 1'b0;
    r.exc   = EXC_NONE;
    r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/fetch_decode_reg_addr_check.sv
// Combinational legality check for an instruction fetch address.
module fetch_addr_check #(
  parameter logic [31:0] IMEM_LO = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI = 32'h0000_6FFC
) (
  input  logic [31:0] i_pc,
  output logic        o_misaligned,
  output logic        o_out_of_range
);

  // Word alignment and unsigned window test against instruction memory.
  always_comb begin
    o_misaligned   = (i_pc[1:0] != 2'b00);
    o_out_of_range = (i_pc < IMEM_LO) || (i_pc > IMEM_HI);
  end

endmodule

// File: rtl/fetch_decode_reg.sv
// F-to-D pipeline register: captures the fetched instruction and its PC,
// tags faulting fetches with AdEL, supports stall/flush and counts issues.
module fetch_decode_reg
  import fetch_decode_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        En,
  input  logic        Flush,
  input  logic [31:0] Instr_F,
  input  logic [31:0] PC_F,
  input  logic        BD_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        BD_D,
  output logic [4:0]  Exc_D,
  output logic        Valid_D,
  output logic [31:0] IssueCnt
);

  localparam d_regs_t ResetD = reset_regs(RESET_PC);

  // Initialisers give the reset state at time zero in simulation.
  d_regs_t     r_d         = ResetD;
  logic [31:0] r_issue_cnt = 32'h0000_0000;

  stage_act_e  w_act;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_fetch_bad;
  d_regs_t     w_d_next;
  logic [31:0] w_issue_cnt_next;

  fetch_addr_check #(
    .IMEM_LO (IMEM_LO),
    .IMEM_HI (IMEM_HI)
  ) u_fetch_addr_check (
    .i_pc           (PC_F),
    .o_misaligned   (w_misaligned),
    .o_out_of_range (w_out_of_range)
  );

  assign w_fetch_bad = w_misaligned | w_out_of_range;

  // Next D-stage contents and issue count for the resolved action.
  always_comb begin
    w_act            = decode_act(Reset, Flush, En);
    w_d_next         = r_d;
    w_issue_cnt_next = r_issue_cnt;
    unique case (w_act)
      ActReset: begin
        w_d_next         = ResetD;
        w_issue_cnt_next = 32'h0000_0000;
      end
      ActFlush: begin
        // Bubble keeps the F-stage PC so later stages see a coherent PC.
        w_d_next.instr = NOP_INSTR;
        w_d_next.pc    = PC_F;
        w_d_next.pc8   = PC_F + LINK_OFFSET;
        w_d_next.bd    = 1'b0;
        w_d_next.exc   = EXC_NONE;
        w_d_next.valid = 1'b0;
      end
      ActStall: begin
        w_d_next         = r_d;
        w_issue_cnt_next = r_issue_cnt;
      end
      ActAdvance: begin
        // A faulting fetch still issues, as a valid nop carrying AdEL.
        w_d_next.instr   = w_fetch_bad ? NOP_INSTR : Instr_F;
        w_d_next.pc      = PC_F;
        w_d_next.pc8     = PC_F + LINK_OFFSET;
        w_d_next.bd      = BD_F;
        w_d_next.exc     = w_fetch_bad ? EXC_ADEL : EXC_NONE;
        w_d_next.valid   = 1'b1;
        w_issue_cnt_next = r_issue_cnt + 32'd1;
      end
      default: begin
        w_d_next         = r_d;
        w_issue_cnt_next = r_issue_cnt;
      end
    endcase
  end

  // Single registered stage; reset is folded into the next-state decode.
  always_ff @(posedge Clk) begin
    r_d         <= w_d_next;
    r_issue_cnt <= w_issue_cnt_next;
  end

  assign Instr_D  = r_d.instr;
  assign PC_D     = r_d.pc;
  assign PC8_D    = r_d.pc8;
  assign BD_D     = r_d.bd;
  assign Exc_D    = r_d.exc;
  assign Valid_D  = r_d.valid;
  assign IssueCnt = r_issue_cnt;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed scoreboard bench for fetch_decode_reg.
module tb_fetch_decode_reg;

  logic        Clk;
  logic        Reset;
  logic        En;
  logic        Flush;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic        BD_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        BD_D;
  logic [4:0]  Exc_D;
  logic        Valid_D;
  logic [31:0] IssueCnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        bd;
    logic [4:0]  exc;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;

  fetch_decode_reg dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Flush    (Flush),
    .Instr_F  (Instr_F),
    .PC_F     (PC_F),
    .BD_F     (BD_F),
    .Instr_D  (Instr_D),
    .PC_D     (PC_D),
    .PC8_D    (PC8_D),
    .BD_D     (BD_D),
    .Exc_D    (Exc_D),
    .Valid_D  (Valid_D),
    .IssueCnt (IssueCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_reset_model();
    m.instr = 32'h0;
    m.pc    = 32'h3000;
    m.pc8   = 32'h3008;
    m.bd    = 1'b0;
    m.exc   = 5'd0;
    m.valid = 1'b0;
    m.cnt   = 32'h0;
  endtask

  // Drive one cycle of inputs and push the state expected after the edge.
  task automatic drive(input logic rst, input logic fl, input logic en,
                       input logic [31:0] instr, input logic [31:0] pc, input logic bd);
    logic bad;
    Reset = rst; Flush = fl; En = en; Instr_F = instr; PC_F = pc; BD_F = bd;
    bad = (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6FFC);
    if (rst) begin
      set_reset_model();
    end else if (fl) begin
      m.instr = 32'h0; m.pc = pc; m.pc8 = pc + 32'd8;
      m.bd = 1'b0; m.exc = 5'd0; m.valid = 1'b0;
    end else if (en) begin
      m.instr = bad ? 32'h0 : instr; m.pc = pc; m.pc8 = pc + 32'd8;
      m.bd = bd; m.exc = bad ? 5'd4 : 5'd0; m.valid = 1'b1;
      m.cnt = m.cnt + 32'd1;
    end
    exp_q.push_back(m);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".instr"}, Instr_D, e.instr);
      chk({tag, ".pc"},    PC_D,    e.pc);
      chk({tag, ".pc8"},   PC8_D,   e.pc8);
      chk({tag, ".bd"},    {31'b0, BD_D},    {31'b0, e.bd});
      chk({tag, ".exc"},   {27'b0, Exc_D},   {27'b0, e.exc});
      chk({tag, ".valid"}, {31'b0, Valid_D}, {31'b0, e.valid});
      chk({tag, ".cnt"},   IssueCnt, e.cnt);
    end
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    #1;
    compare(tag);
  endtask

  initial begin
    Reset = 1'b0; Flush = 1'b0; En = 1'b0;
    Instr_F = 32'h0; PC_F = 32'h0; BD_F = 1'b0;
    set_reset_model();

    // Time-zero state before any clock edge.
    #1;
    exp_q.push_back(m);
    compare("init");

    drive(1, 0, 0, 32'hDEAD_BEEF, 32'h4000, 1); step("reset");

    drive(0, 0, 1, 32'h3C01_1234, 32'h3000, 0); step("adv0");
    // Spot-check the literal values as well as the model.
    chk("adv0.lit_instr", Instr_D, 32'h3C01_1234);
    chk("adv0.lit_pc8",   PC8_D,   32'h3008);
    chk("adv0.lit_cnt",   IssueCnt, 32'd1);

    drive(0, 0, 0, 32'h1111_1111, 32'h3004, 1); step("stall1");
    drive(0, 0, 0, 32'h2222_2222, 32'h3008, 0); step("stall2");
    drive(0, 0, 0, 32'h3333_3333, 32'h300C, 1); step("stall3");

    drive(0, 0, 1, 32'h2402_0005, 32'h3004, 1); step("adv_bd");

    drive(0, 1, 0, 32'h4444_4444, 32'h3010, 1); step("flush");
    chk("flush.lit_pc", PC_D, 32'h3010);

    drive(0, 0, 1, 32'h5555_5555, 32'h3002, 0); step("misalign");
    drive(0, 0, 1, 32'h6666_6666, 32'h7000, 1); step("above_hi");
    drive(0, 0, 1, 32'h7777_7777, 32'h6FFC, 0); step("at_hi");
    drive(0, 0, 1, 32'h8888_8888, 32'h2FFC, 0); step("below_lo");
    drive(0, 1, 1, 32'h9999_9999, 32'h3020, 1); step("flush_en");

    // Preload the counter to its maximum during a stall, then advance.
    drive(0, 0, 0, 32'h0, 32'h3024, 0);
    force dut.r_issue_cnt = 32'hFFFF_FFFF;
    @(posedge Clk);
    #1;
    release dut.r_issue_cnt;
    exp_q[0].cnt = 32'hFFFF_FFFF;
    m.cnt = 32'hFFFF_FFFF;
    compare("cnt_max");
    drive(0, 0, 1, 32'hAAAA_AAAA, 32'h3028, 0); step("cnt_wrap");

    // Reset arriving in the middle of a stall, with Flush and En also high.
    drive(0, 0, 1, 32'hBBBB_BBBB, 32'h302C, 1); step("pre_stall");
    drive(0, 0, 0, 32'hCCCC_CCCC, 32'h3030, 0); step("stall_hold");
    drive(1, 1, 1, 32'hDDDD_DDDD, 32'h3034, 1); step("reset_all");

    drive(0, 0, 1, 32'hEEEE_EEEE, 32'h3000, 0); step("post_reset");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
